// File: rtl/apb3_completer_mem.sv
// apb3_completer_mem
// APB3 completer backed by a word-addressed memory window.
// Transfers complete after a configurable number of wait states.
// Misaligned or out-of-window accesses answer with PSLVERR.
// Successful reads and writes are counted in two wrapping 16-bit counters.
//
// Optional build macro: APB3_COMPLETER_PROTOCOL_CHECK_EN
//   When defined, a sticky protocol_err flag watches for requester-side
//   protocol violations. To detect changes during the access phase, the
//   setup-phase address, direction and write data are captured.
//   When undefined, protocol_err is tied low and no capture logic is built.

module apb3_completer_mem #(
    parameter int                      AddressWidth = 20,
    parameter int                      DataWidth    = 32,
    parameter logic [AddressWidth-1:0] MemoryOffset = 20'h0_1000,
    parameter int                      Depth        = 64,
    parameter int                      WaitStates   = 0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [AddressWidth-1:0] paddr,
    input  logic                    pselx,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DataWidth-1:0]    pwdata,
    output logic                    pready,
    output logic [DataWidth-1:0]    prdata,
    output logic                    pslverr,
    output logic [15:0]             write_count,
    output logic [15:0]             read_count,
    output logic                    protocol_err
);

    localparam int IndexWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [AddressWidth:0] WindowBytes = (AddressWidth + 1)'(4 * Depth);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              wait_cnt;
    logic [7:0]              wait_cnt_next;
    logic [AddressWidth:0]   off;
    logic                    hit;
    logic [IndexWidth-1:0]   index;
    logic                    wr_en;
    logic                    rd_done;
    logic [DataWidth-1:0]    mem [Depth];

    // Address decode.
    // The offset carries one extra bit, so addresses below the window
    // cannot alias back into it.
    assign off   = {1'b0, paddr} - {1'b0, MemoryOffset};
    assign hit   = (paddr >= MemoryOffset) && (off < WindowBytes) && (paddr[1:0] == 2'b00);
    assign index = off[IndexWidth+1:2];

    // The transfer completes on the edge at which pready is high.
    assign pready  = (state == S_ACCESS) && pselx && penable && (wait_cnt == 8'd0);
    assign pslverr = pready && !hit;
    assign wr_en   = pready && hit && pwrite;
    assign rd_done = pready && hit && !pwrite;
    assign prdata  = (pready && !pwrite && hit) ? mem[index] : '0;

    // FSM state and wait-state counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state logic.
    // Setup loads the wait count, the access phase counts it down,
    // and a deselect aborts the transfer.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            S_IDLE: begin
                if (pselx && !penable) begin
                    state_next    = S_ACCESS;
                    wait_cnt_next = 8'(WaitStates);
                end
            end
            S_ACCESS: begin
                if (!pselx) begin
                    state_next = S_IDLE;
                end else if (wait_cnt != 8'd0) begin
                    wait_cnt_next = wait_cnt - 8'd1;
                end else if (penable) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Memory write port.
    // The contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[index] <= pwdata;
        end
    end

    // Counters for successful transfers; they wrap naturally at 16 bits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            write_count <= 16'd0;
            read_count  <= 16'd0;
        end else begin
            if (wr_en) begin
                write_count <= write_count + 16'd1;
            end
            if (rd_done) begin
                read_count <= read_count + 16'd1;
            end
        end
    end

`ifdef APB3_COMPLETER_PROTOCOL_CHECK_EN
    logic [AddressWidth-1:0] cap_addr;
    logic                    cap_write;
    logic [DataWidth-1:0]    cap_wdata;
    logic                    violation;
    logic                    protocol_err_q;

    // Capture the setup-phase transfer attributes.
    // They are compared against the bus throughout the access phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
        end else if ((state == S_IDLE) && pselx && !penable) begin
            cap_addr  <= paddr;
            cap_write <= pwrite;
            cap_wdata <= pwdata;
        end
    end

    // Flag any requester behaviour that breaks the setup/access sequence
    always_comb begin
        violation = 1'b0;
        if ((state == S_IDLE) && penable) begin
            violation = 1'b1;
        end
        if ((state == S_ACCESS) && pselx && !penable) begin
            violation = 1'b1;
        end
        if ((state == S_ACCESS) &&
            ((paddr != cap_addr) || (pwrite != cap_write) || (pwdata != cap_wdata))) begin
            violation = 1'b1;
        end
    end

    // Sticky error flag; only reset clears it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            protocol_err_q <= 1'b0;
        end else if (violation) begin
            protocol_err_q <= 1'b1;
        end
    end

    assign protocol_err = protocol_err_q;
`else
    assign protocol_err = 1'b0;
`endif

endmodule
